// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage load/store unit for the 5-stage MIPS pipeline.
// Issues one data-memory transfer at a time over a req/ack handshake, stalls
// upstream while it is outstanding, aligns/extends load data and registers
// the writeback bundle for MEM/WB.
// Optional build macro: LSU_TIMEOUT_EN adds an ack timeout (TIMEOUT cycles)
// and the bus_err output.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [6:0]  ex_wb,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [6:0]  mem_wb,
    output logic [31:0] mem_rdata,
    output logic [31:0] mem_alu,
`ifdef LSU_TIMEOUT_EN
    output logic        misalign_exc,
    output logic        bus_err
`else
    output logic        misalign_exc
`endif
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Copy of the in-flight instruction, used while BUSY and at completion
    logic [6:0]  r_wb;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_is_load;

    logic        w_is_mem;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_capture;

    logic        w_req_nxt;
    logic        w_we_nxt;
    logic [31:0] w_daddr_nxt;
    logic [3:0]  w_be_nxt;
    logic [31:0] w_dwdata_nxt;
    logic [6:0]  w_wb_nxt;
    logic [31:0] w_rdata_nxt;
    logic [31:0] w_alu_nxt;
    logic        w_mis_nxt;

`ifdef LSU_TIMEOUT_EN
    logic [7:0]  r_tmo_cnt;
    logic        w_tmo_hit;
    logic        w_berr_nxt;

    // Terminal count reached with no ack this cycle; an ack wins
    assign w_tmo_hit = (r_state == ST_BUSY) && !dmem_ack
                       && (r_tmo_cnt == 8'(TIMEOUT - 1));

    // Count BUSY cycles without ack; cleared in IDLE and on abort
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_BUSY && !dmem_ack && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    logic        w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT != 0);
`endif

    // Decode the EX/MEM instruction: alignment, byte enables, store lanes
    always_comb begin
        w_is_mem = ex_valid && (ex_mem_rd || ex_mem_wr);
        case (ex_size)
            2'b00: begin
                w_misalign = 1'b0;
                w_be       = 4'b0001 << ex_addr[1:0];
                w_wdata    = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                w_misalign = ex_addr[0];
                w_be       = 4'b0011 << ex_addr[1:0];
                w_wdata    = {2{ex_wdata[15:0]}};
            end
            default: begin
                w_misalign = |ex_addr[1:0];
                w_be       = 4'b1111;
                w_wdata    = ex_wdata;
            end
        endcase
    end

    // Little-endian lane select and sign/zero extension of the read word
    always_comb begin
        w_byte = dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half = dmem_rdata[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    // Next-state, stall and next values for every registered output
    always_comb begin
        w_state_nxt  = r_state;
        mem_stall    = 1'b0;
        w_capture    = 1'b0;
        w_req_nxt    = dmem_req;
        w_we_nxt     = dmem_we;
        w_daddr_nxt  = dmem_addr;
        w_be_nxt     = dmem_be;
        w_dwdata_nxt = dmem_wdata;
        w_wb_nxt     = '0;
        w_rdata_nxt  = '0;
        w_alu_nxt    = mem_alu;
        w_mis_nxt    = 1'b0;
`ifdef LSU_TIMEOUT_EN
        w_berr_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem && !w_misalign) begin
                    mem_stall    = 1'b1;
                    w_capture    = 1'b1;
                    w_req_nxt    = 1'b1;
                    w_we_nxt     = ex_mem_wr;
                    w_daddr_nxt  = {ex_addr[31:2], 2'b00};
                    w_be_nxt     = w_be;
                    w_dwdata_nxt = w_wdata;
                    w_state_nxt  = ST_BUSY;
                end else if (w_is_mem) begin
                    w_mis_nxt = 1'b1;
                    w_wb_nxt  = {2'b00, ex_wb[4:0]};
                    w_alu_nxt = ex_addr;
                end else begin
                    w_wb_nxt  = ex_valid ? ex_wb : '0;
                    w_alu_nxt = ex_addr;
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_wb_nxt    = r_wb;
                    w_rdata_nxt = r_is_load ? w_load : '0;
                    w_alu_nxt   = r_addr;
                    w_state_nxt = ST_IDLE;
                end
`ifdef LSU_TIMEOUT_EN
                // Stall drops in the abort cycle so the faulting op retires
                // instead of being re-issued from a held EX/MEM register.
                else if (w_tmo_hit) begin
                    w_req_nxt   = 1'b0;
                    w_berr_nxt  = 1'b1;
                    w_wb_nxt    = {2'b00, r_wb[4:0]};
                    w_alu_nxt   = r_addr;
                    w_state_nxt = ST_IDLE;
                end
`endif
                else begin
                    mem_stall = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered memory request, writeback bundle and held instruction
    always_ff @(posedge clk) begin
        if (!rst) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            mem_wb       <= '0;
            mem_rdata    <= '0;
            mem_alu      <= '0;
            misalign_exc <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_err      <= 1'b0;
`endif
            r_wb         <= '0;
            r_addr       <= '0;
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_is_load    <= 1'b0;
        end else begin
            dmem_req     <= w_req_nxt;
            dmem_we      <= w_we_nxt;
            dmem_addr    <= w_daddr_nxt;
            dmem_be      <= w_be_nxt;
            dmem_wdata   <= w_dwdata_nxt;
            mem_wb       <= w_wb_nxt;
            mem_rdata    <= w_rdata_nxt;
            mem_alu      <= w_alu_nxt;
            misalign_exc <= w_mis_nxt;
`ifdef LSU_TIMEOUT_EN
            bus_err      <= w_berr_nxt;
`endif
            if (w_capture) begin
                r_wb      <= ex_wb;
                r_addr    <= ex_addr;
                r_size    <= ex_size;
                r_uns     <= ex_unsigned;
                r_is_load <= ex_mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu. The driver plays the
// upstream pipeline and the data memory; expected retirements and bus
// requests are queued at issue time and checked by independent monitors.
// Timeout cases are compiled in when LSU_TIMEOUT_EN is defined.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_unsigned;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic [6:0]  ex_wb;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [6:0]  mem_wb;
    logic [31:0] mem_rdata, mem_alu;
    logic        misalign_exc;
    logic        tb_bus_err;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_mem_rd    (ex_mem_rd),
        .ex_mem_wr    (ex_mem_wr),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_wb        (ex_wb),
        .mem_stall    (mem_stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .mem_wb       (mem_wb),
        .mem_rdata    (mem_rdata),
        .mem_alu      (mem_alu),
`ifdef LSU_TIMEOUT_EN
        .misalign_exc (misalign_exc),
        .bus_err      (tb_bus_err)
`else
        .misalign_exc (misalign_exc)
`endif
    );

`ifndef LSU_TIMEOUT_EN
    assign tb_bus_err = 1'b0;
`endif

    typedef struct {
        logic [6:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic        mis;
        logic        berr;
    } ret_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    ret_t ret_q[$];
    req_t req_q[$];
    int   checks = 0;
    int   passes = 0;
    logic mon_en = 1'b0;
    logic prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    task automatic expect_ret(input logic [6:0] wb, input logic [31:0] rdata,
                              input logic [31:0] alu, input logic mis, input logic berr);
        ret_t e;
        e.wb = wb; e.rdata = rdata; e.alu = alu; e.mis = mis; e.berr = berr;
        ret_q.push_back(e);
    endtask

    task automatic expect_req(input logic we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.be = be; r.wdata = wdata;
        req_q.push_back(r);
    endtask

    // Retirement monitor: any visible writeback/exception output must match
    // the oldest queued expectation
    always @(negedge clk) begin
        ret_t e;
        if (mon_en && (mem_wb != 7'd0 || misalign_exc || tb_bus_err)) begin
            if (ret_q.size() == 0) begin
                checks++;
                $display("FAIL retire_unexpected: got wb=0x%02h mis=%0b berr=%0b want no output",
                         mem_wb, misalign_exc, tb_bus_err);
            end else begin
                e = ret_q.pop_front();
                chk("retire_wb",    {25'd0, mem_wb},       {25'd0, e.wb});
                chk("retire_rdata", mem_rdata,             e.rdata);
                chk("retire_alu",   mem_alu,               e.alu);
                chk("retire_mis",   {31'd0, misalign_exc}, {31'd0, e.mis});
                chk("retire_berr",  {31'd0, tb_bus_err},   {31'd0, e.berr});
            end
        end
    end

    // Bus monitor: each new request must match the oldest queued request
    always @(negedge clk) begin
        req_t r;
        if (mon_en && dmem_req && !prev_req) begin
            if (req_q.size() == 0) begin
                checks++;
                $display("FAIL req_unexpected: got addr=0x%08h be=%b want no request",
                         dmem_addr, dmem_be);
            end else begin
                r = req_q.pop_front();
                chk("req_we",    {31'd0, dmem_we}, {31'd0, r.we});
                chk("req_addr",  dmem_addr,        r.addr);
                chk("req_be",    {28'd0, dmem_be}, {28'd0, r.be});
                chk("req_wdata", dmem_wdata,       r.wdata);
            end
        end
        prev_req <= dmem_req;
    end

    // Present one instruction, serve memory after ack_wait no-ack BUSY
    // cycles, and check how many cycles mem_stall was high
    task automatic issue(input logic v, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [6:0] wb, input int ack_wait,
                         input logic [31:0] rdata, input int exp_stall,
                         input string tag);
        int stalls = 0;
        int busy   = 0;
        @(posedge clk); #1;
        ex_valid = v; ex_mem_rd = rd; ex_mem_wr = wr; ex_size = sz;
        ex_unsigned = uns; ex_addr = addr; ex_wdata = wdata; ex_wb = wb;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        if (mem_stall) stalls++;
        while (mem_stall) begin
            if (busy >= 64) begin
                checks++;
                $display("FAIL %s_ack_wait: got stall after %0d cycles want release", tag, busy);
                break;
            end
            @(posedge clk); #1;
            busy++;
            if (busy > ack_wait) begin
                dmem_ack = 1'b1; dmem_rdata = rdata;
            end else begin
                dmem_ack = 1'b0; dmem_rdata = 32'h0;
            end
            @(negedge clk);
            if (mem_stall) stalls++;
        end
        chk({tag, "_stall_cycles"}, stalls, exp_stall);
    endtask

    task automatic idle(input logic ack, input string tag);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
        dmem_ack = ack; dmem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_size = 2'b00;
        ex_unsigned = 1'b0; ex_addr = 32'h0; ex_wdata = 32'h0; ex_wb = 7'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_wb",    {25'd0, mem_wb},       32'd0);
        chk("rst_mem_rdata", mem_rdata,             32'd0);
        chk("rst_mem_alu",   mem_alu,               32'd0);
        chk("rst_misalign",  {31'd0, misalign_exc}, 32'd0);
        chk("rst_bus_err",   {31'd0, tb_bus_err},   32'd0);
        chk("rst_req",       {31'd0, dmem_req},     32'd0);
        chk("rst_we",        {31'd0, dmem_we},      32'd0);
        chk("rst_addr",      dmem_addr,             32'd0);
        chk("rst_be",        {28'd0, dmem_be},      32'd0);
        chk("rst_wdata",     dmem_wdata,            32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;

        expect_ret(7'h45, 32'h0, 32'h1234, 1'b0, 1'b0);
        issue(1, 0, 0, 2'b10, 0, 32'h1234, 32'h0, 7'h45, 0, 32'h0, 0, "alu");

        expect_req(1'b0, 32'h1000, 4'b1000, 32'h0);
        expect_ret(7'h61, 32'hFFFFFF80, 32'h1003, 1'b0, 1'b0);
        issue(1, 1, 0, 2'b00, 0, 32'h1003, 32'h0, 7'h61, 3, 32'h80FFFFFF, 4, "lb");

        expect_req(1'b0, 32'h1000, 4'b1000, 32'h0);
        expect_ret(7'h62, 32'h00000080, 32'h1003, 1'b0, 1'b0);
        issue(1, 1, 0, 2'b00, 1, 32'h1003, 32'h0, 7'h62, 3, 32'h80FFFFFF, 4, "lbu");

        expect_req(1'b1, 32'h2000, 4'b1100, 32'hBEEFBEEF);
        expect_ret(7'h05, 32'h0, 32'h2002, 1'b0, 1'b0);
        issue(1, 0, 1, 2'b01, 0, 32'h2002, 32'h0000BEEF, 7'h05, 0, 32'hFFFFFFFF, 1, "sh");

        expect_ret(7'h03, 32'h0, 32'h3001, 1'b1, 1'b0);
        issue(1, 1, 0, 2'b10, 0, 32'h3001, 32'h0, 7'h63, 0, 32'h0, 0, "lw_mis");
        idle(1'b0, "after_mis");

        expect_req(1'b0, 32'h1000, 4'b1100, 32'h0);
        expect_ret(7'h64, 32'hFFFF8001, 32'h1002, 1'b0, 1'b0);
        issue(1, 1, 0, 2'b01, 0, 32'h1002, 32'h0, 7'h64, 1, 32'h80011234, 2, "lh");

        expect_req(1'b0, 32'h1000, 4'b0011, 32'h0);
        expect_ret(7'h65, 32'h0000F00D, 32'h1000, 1'b0, 1'b0);
        issue(1, 1, 0, 2'b01, 1, 32'h1000, 32'h0, 7'h65, 0, 32'hABCDF00D, 1, "lhu");

        expect_req(1'b0, 32'h1000, 4'b0010, 32'h0);
        expect_ret(7'h6A, 32'h0000007F, 32'h1001, 1'b0, 1'b0);
        issue(1, 1, 0, 2'b00, 0, 32'h1001, 32'h0, 7'h6A, 0, 32'h00007F00, 1, "lb_pos");

        expect_req(1'b1, 32'h5000, 4'b0010, 32'hA7A7A7A7);
        expect_ret(7'h06, 32'h0, 32'h5001, 1'b0, 1'b0);
        issue(1, 0, 1, 2'b00, 0, 32'h5001, 32'h123456A7, 7'h06, 2, 32'h0, 3, "sb");

        expect_req(1'b1, 32'h6000, 4'b1111, 32'hDEADBEEF);
        expect_ret(7'h07, 32'h0, 32'h6000, 1'b0, 1'b0);
        issue(1, 0, 1, 2'b10, 0, 32'h6000, 32'hDEADBEEF, 7'h07, 0, 32'h0, 1, "sw");

        expect_req(1'b0, 32'h7000, 4'b1111, 32'h0);
        expect_ret(7'h66, 32'hCAFEF00D, 32'h7000, 1'b0, 1'b0);
        issue(1, 1, 0, 2'b11, 0, 32'h7000, 32'h0, 7'h66, 1, 32'hCAFEF00D, 2, "lw_sz3");

        expect_ret(7'h07, 32'h0, 32'h2001, 1'b1, 1'b0);
        issue(1, 0, 1, 2'b01, 0, 32'h2001, 32'h1111, 7'h27, 0, 32'h0, 0, "sh_mis");

        issue(0, 1, 0, 2'b10, 0, 32'h9000, 32'h0, 7'h55, 0, 32'h0, 0, "bubble");
        idle(1'b1, "idle_ack");
        idle(1'b0, "idle");

`ifdef LSU_TIMEOUT_EN
        expect_req(1'b0, 32'h8000, 4'b1111, 32'h0);
        expect_ret(7'h08, 32'h0, 32'h8000, 1'b0, 1'b1);
        issue(1, 1, 0, 2'b10, 0, 32'h8000, 32'h0, 7'h68, 1000, 32'h0, 4, "lw_tmo");
        idle(1'b0, "after_tmo");

        expect_req(1'b0, 32'h8004, 4'b1111, 32'h0);
        expect_ret(7'h69, 32'h11223344, 32'h8004, 1'b0, 1'b0);
        issue(1, 1, 0, 2'b10, 0, 32'h8004, 32'h0, 7'h69, 3, 32'h11223344, 4, "lw_tmo_ack");
`endif

        // Reset held for one cycle while BUSY, then a late ack
        expect_req(1'b0, 32'h4000, 4'b1111, 32'h0);
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_size = 2'b10;
        ex_unsigned = 1'b0; ex_addr = 32'h4000; ex_wb = 7'h6B; dmem_ack = 1'b0;
        @(negedge clk);
        chk("rstbusy_stall_issue", {31'd0, mem_stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstbusy_req_before", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; ex_valid = 1'b0; ex_mem_rd = 1'b0;
        @(negedge clk);
        chk("rstbusy_req",    {31'd0, dmem_req},  32'd0);
        chk("rstbusy_wb",     {25'd0, mem_wb},    32'd0);
        chk("rstbusy_alu",    mem_alu,            32'd0);
        chk("rstbusy_addr",   dmem_addr,          32'd0);
        chk("rstbusy_be",     {28'd0, dmem_be},   32'd0);
        chk("rstbusy_stall",  {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        chk("late_ack_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_wb",    {25'd0, mem_wb},    32'd0);
        chk("late_ack_rdata", mem_rdata,          32'd0);

        expect_ret(7'h4A, 32'h0, 32'h0ABC, 1'b0, 1'b0);
        issue(1, 0, 0, 2'b00, 0, 32'h0ABC, 32'h0, 7'h4A, 0, 32'h0, 0, "post_rst");
        idle(1'b0, "drain0");
        idle(1'b0, "drain1");

        chk("ret_q_empty", ret_q.size(), 32'd0);
        chk("req_q_empty", req_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Issues loads and stores to the data memory over a req/ack handshake and stalls upstream while a transfer is outstanding.
- Byte-aligns and sign- or zero-extends load data.
- Produces the registered 7-bit writeback bundle plus data that the MEM/WB register consumes.

Parameters:
- TIMEOUT, 16, cycles to wait for dmem_ack before aborting. Used only when LSU_TIMEOUT_EN is defined; range 2..255.

Ports:
- clk  input  1  pipeline clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge
- ex_valid  input  1  EX/MEM slot holds a real instruction
- ex_mem_rd  input  1  instruction is a load
- ex_mem_wr  input  1  instruction is a store; ex_mem_rd and ex_mem_wr are never both 1
- ex_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word
- ex_unsigned  input  1  zero-extend loads (lbu/lhu)
- ex_addr  input  32  ALU result / effective address
- ex_wdata  input  32  store data, right-justified
- ex_wb  input  7  {RegWrite, MemtoReg, rd[4:0]}
- mem_stall  output  1  hold PC/IF/ID/EX and EX/MEM
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word address, {ex_addr[31:2],2'b00}
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-replicated store data
- dmem_ack  input  1  transfer complete; dmem_rdata valid in same cycle
- dmem_rdata  input  32  read word
- mem_wb  output  7  writeback bundle to MEM/WB
- mem_rdata  output  32  aligned, extended load data
- mem_alu  output  32  pass-through ALU result
- misalign_exc  output  1  one-cycle address-error pulse
- bus_err  output  1  one-cycle timeout pulse; exists only with LSU_TIMEOUT_EN

Behaviour:
- Reset (rst=0 at edge):
  - State goes to IDLE.
  - All registered outputs go to 0: mem_wb, mem_rdata, mem_alu, misalign_exc, bus_err, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata.
  - Timeout counter clears.
- Endianness: little-endian; byte lane = ex_addr[1:0].
- Alignment rules:
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load alignment: shift dmem_rdata right by 8*addr[1:0]; keep 8 or 16 bits; sign-extend, or zero-extend if ex_unsigned; word loads are unchanged.
- State machine: IDLE, BUSY.
- IDLE, non-memory op (or ex_valid=0):
  - mem_stall=0.
  - Next edge: mem_wb<=ex_valid?ex_wb:0, mem_alu<=ex_addr, mem_rdata<=0.
  - Latency is 1 cycle.
- IDLE, aligned load/store:
  - mem_stall=1 combinationally in that same cycle.
  - Next edge: dmem_req/we/addr/be/wdata registered; request fields are held stable until ack; go to BUSY; mem_wb<=0 (bubble).
- BUSY, dmem_ack=0:
  - mem_stall=1, mem_wb=0.
- BUSY, dmem_ack=1:
  - mem_stall=0 in the ack cycle, so upstream advances at that edge.
  - Next edge: dmem_req<=0; mem_wb<=held wb bundle; mem_rdata<=aligned data for loads, 0 for stores; mem_alu<=held address; go to IDLE.
  - Minimum load-to-writeback latency is 2 cycles (request edge plus ack edge).
- A new memory op can be accepted in the first IDLE cycle after ack. The bus never sees back-to-back req without one idle cycle.
- Misaligned op in IDLE:
  - No dmem_req, no stall.
  - Next edge: misalign_exc<=1 for exactly one cycle; mem_wb<={2'b00, rd}, i.e. RegWrite and MemtoReg forced 0.
- dmem_ack while IDLE is ignored.
- Reset while BUSY: the request is dropped the following cycle and any later ack is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each BUSY cycle without ack.
  - When it reaches TIMEOUT-1 without ack: next edge deasserts dmem_req, pulses bus_err for 1 cycle, writes mem_wb={2'b00,rd}, returns to IDLE, clears the counter.
  - An ack in the same cycle as the terminal count wins (normal completion).
- Not defined: no counter, no bus_err port; BUSY waits indefinitely.

Test Plan:
- Non-memory op: ex_valid=1, ex_wb=7'h45, ex_addr=32'h1234 -> next cycle mem_wb=7'h45, mem_alu=32'h1234, mem_stall never 1.
- lb, addr=0x1003, ack after 3 BUSY cycles, rdata=0x80FFFFFF -> dmem_be=0001 shifted to 1000, dmem_addr=0x1000; mem_stall high 4 cycles; mem_rdata=0xFFFFFF80. Same with lbu -> 0x00000080.
- sh, addr=0x2002, wdata=0x0000BEEF, immediate ack -> dmem_we=1, be=1100, wdata=0xBEEFBEEF; mem_wb has RegWrite=0 as supplied; mem_rdata=0.
- lw, addr=0x3001 -> no dmem_req; misalign_exc pulses 1 cycle; mem_wb[6:5]=00; no stall.
- Reset (rst=0) held 1 cycle during BUSY, then a late dmem_ack -> all outputs 0, state IDLE, late ack produces no mem_wb.
- LSU_TIMEOUT_EN, TIMEOUT=4, never ack -> dmem_req falls, bus_err pulses exactly once after 4 BUSY cycles, mem_stall releases; with ack on the 4th BUSY cycle -> normal completion, no bus_err.
